// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and types for the data-memory arbiter
//
// Holds the data-memory map, the arbiter FSM state encoding and the master
// index constants used by dmem_arbiter. No ports.

package dmem_arbiter_pkg;

    // Memory map: bus address of data-memory word 0.
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0001_0000;

    // Master indices (also the encoding of the last-grant register).
    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    // Arbiter FSM state encoding.
    typedef enum logic [0:0] {
        ARB_S    = 1'b0,
        FORCE1_S = 1'b1
    } arb_state_t;

    // Bank-relative address of a bus address.
    function automatic logic [31:0] dmem_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter in front of the byte-banked data memory
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m0_req/we/addr/wdata            CPU request (we=0000 is a read)
//   m0_gnt, m0_rvalid, m0_rdata     CPU grant and read return
//   m1_*                            loader/debug master, same set as m0
//   mem_we/addr/wdata, mem_rdata    bank port (address relative to BASE_ADDR,
//                                   read data one cycle after the address)
//   m0_starved                      one-cycle pulse when a forced m1 grant preempts m0
//
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration instead of
// fixed priority with starvation forcing (m0_starved then tied to 0).

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR,
    parameter logic [3:0]  STARVE_LIMIT = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        m0_starved
);

    // Raw grant decisions; the outputs are these gated with rst_n so that
    // nothing leaves the block while reset is held.
    logic gnt0_c;
    logic gnt1_c;
    logic starved_c;

`ifdef DMEM_ARB_RR_EN

    // Round-robin: on a tie, the master not granted last wins. Resetting
    // the last-grant register to m1 lets m0 win the first tie.
    logic last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= M1_IDX;
        end else if (gnt0_c) begin
            last_gnt <= M0_IDX;
        end else if (gnt1_c) begin
            last_gnt <= M1_IDX;
        end
    end

    always_comb begin
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        starved_c = 1'b0;
        if (m0_req && m1_req) begin
            if (last_gnt == M1_IDX) begin
                gnt0_c = 1'b1;
            end else begin
                gnt1_c = 1'b1;
            end
        end else if (m0_req) begin
            gnt0_c = 1'b1;
        end else if (m1_req) begin
            gnt1_c = 1'b1;
        end
    end

`else

    arb_state_t state;
    arb_state_t state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_inc;
    logic       m1_waiting;

    assign m1_waiting = m1_req && !gnt1_c;
    // Saturating increment: the counter clamps at the limit.
    assign starve_inc = (starve_cnt == STARVE_LIMIT) ? starve_cnt : starve_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (m1_waiting) begin
            starve_cnt <= starve_inc;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_S;
        end else begin
            state <= state_nxt;
        end
    end

    // The switch to FORCE1 is taken on the edge where the counter reaches
    // the limit, so the forced grant lands in the cycle the count shows it.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_S: begin
                if (m1_waiting && (starve_inc == STARVE_LIMIT)) begin
                    state_nxt = FORCE1_S;
                end
            end
            FORCE1_S: state_nxt = ARB_S;
            default:  state_nxt = ARB_S;
        endcase
    end

    // FORCE1 withholds m0 for one cycle even if m1 has dropped its request.
    always_comb begin
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        starved_c = 1'b0;
        case (state)
            ARB_S: begin
                gnt0_c = m0_req;
                gnt1_c = !m0_req && m1_req;
            end
            FORCE1_S: begin
                gnt1_c    = m1_req;
                starved_c = m1_req && m0_req;
            end
            default: begin
                gnt0_c = 1'b0;
            end
        endcase
    end

`endif

    assign m0_gnt     = rst_n && gnt0_c;
    assign m1_gnt     = rst_n && gnt1_c;
    assign m0_starved = rst_n && starved_c;

    // Request steering to the banks.
    logic        any_gnt;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        below_base;

    assign any_gnt = m0_gnt || m1_gnt;

    always_comb begin
        sel_we    = 4'd0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        if (m0_gnt) begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end else if (m1_gnt) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // Accesses below the data-memory window never write the banks and read
    // back as zero.
    assign below_base = sel_addr < BASE_ADDR;
    assign mem_we     = (any_gnt && !below_base) ? sel_we : 4'd0;
    assign mem_addr   = any_gnt ? dmem_offset(sel_addr, BASE_ADDR) : 32'd0;
    assign mem_wdata  = any_gnt ? sel_wdata : 32'd0;

    // Read-return steering: remember who issued last cycle's read and
    // whether it was outside the window, then route mem_rdata accordingly.
    logic rd_pend0;
    logic rd_pend1;
    logic rd_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            rd_zero  <= 1'b0;
        end else begin
            rd_pend0 <= m0_gnt && (m0_we == 4'd0);
            rd_pend1 <= m1_gnt && (m1_we == 4'd0);
            rd_zero  <= below_base;
        end
    end

    logic [31:0] ret_data;
    assign ret_data = rd_zero ? 32'd0 : mem_rdata;

    assign m0_rvalid = rd_pend0;
    assign m1_rvalid = rd_pend1;
    assign m0_rdata  = rd_pend0 ? ret_data : 32'd0;
    assign m1_rdata  = rd_pend1 ? ret_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        m0_starved;

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .m0_starved(m0_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four byte-wide banks, synchronous read one cycle after the address.
    logic [31:0] bank [256];
    initial begin
        for (int i = 0; i < 256; i++) bank[i] = 32'd0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (mem_we[l]) bank[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
        mem_rdata <= bank[mem_addr[9:2]];
    end

    typedef struct {
        logic        m0_req;
        logic [3:0]  m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic [3:0]  m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        e_m0_gnt;
        logic        e_m1_gnt;
        logic [3:0]  e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_m0_rv;
        logic [31:0] e_m0_rd;
        logic        e_m1_rv;
        logic [31:0] e_m1_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic [3:0] we, input logic [31:0] a,
                          input logic [31:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic req, input logic [3:0] we, input logic [31:0] a,
                          input logic [31:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic check_all_zero(input string name, input int idx);
        check({name, "_m0_gnt"}, idx, {31'd0, m0_gnt}, 32'd0);
        check({name, "_m1_gnt"}, idx, {31'd0, m1_gnt}, 32'd0);
        check({name, "_mem_we"}, idx, {28'd0, mem_we}, 32'd0);
        check({name, "_mem_addr"}, idx, mem_addr, 32'd0);
        check({name, "_mem_wdata"}, idx, mem_wdata, 32'd0);
        check({name, "_m0_rvalid"}, idx, {31'd0, m0_rvalid}, 32'd0);
        check({name, "_m0_rdata"}, idx, m0_rdata, 32'd0);
        check({name, "_m1_rvalid"}, idx, {31'd0, m1_rvalid}, 32'd0);
        check({name, "_m1_rdata"}, idx, m1_rdata, 32'd0);
        check({name, "_starved"}, idx, {31'd0, m0_starved}, 32'd0);
    endtask

    int n_m0, n_m1, n_st, first_m1;

    initial begin
        //            m0 req we     addr           wdata          m1 req we     addr           wdata          g0 g1 mwe    maddr          mwdata         rv0 rd0           rv1 rd1
        vecs[0]  = '{1'b0, 4'h0, 32'h0001_0044, 32'h1111_1111, 1'b0, 4'hF, 32'h0001_0048, 32'h2222_2222, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'hF, 32'h0001_0008, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 4'h0, 32'h0001_0008, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'hF, 32'h0001_0100, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 4'h0, 32'hFFFF_0100, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 32'h0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b1, 4'h0, 32'hFFFF_0200, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'h4, 32'h0001_0002, 32'h00AA_0000, 1'b0, 1'b1, 4'h4, 32'h0000_0002, 32'h00AA_0000, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'h0, 32'h0001_0008, 32'h0,         1'b1, 4'h0, 32'h0001_0100, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'h0, 32'h0001_0100, 32'h0,         1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'hF, 32'h0001_0010, 32'h5555_AAAA, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 32'h0, 1'b1, 32'h1234_5678};
        vecs[12] = '{1'b1, 4'h0, 32'h0001_0000, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'h00AA_0000, 1'b0, 32'h0};

        // Reset: requests asserted, every output must stay at 0.
        rst_n = 1'b0;
        set_m0(1'b1, 4'hF, 32'h0001_0004, 32'hAAAA_5555);
        set_m1(1'b1, 4'h0, 32'h0001_000C, 32'h0);
        @(negedge clk);
        #2;
        check_all_zero("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_m0(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata);
            set_m1(vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata);
            #2;
            check("m0_gnt", i, {31'd0, m0_gnt}, {31'd0, vecs[i].e_m0_gnt});
            check("m1_gnt", i, {31'd0, m1_gnt}, {31'd0, vecs[i].e_m1_gnt});
            check("mem_we", i, {28'd0, mem_we}, {28'd0, vecs[i].e_mem_we});
            check("mem_addr", i, mem_addr, vecs[i].e_mem_addr);
            check("mem_wdata", i, mem_wdata, vecs[i].e_mem_wdata);
            check("m0_rvalid", i, {31'd0, m0_rvalid}, {31'd0, vecs[i].e_m0_rv});
            check("m0_rdata", i, m0_rdata, vecs[i].e_m0_rd);
            check("m1_rvalid", i, {31'd0, m1_rvalid}, {31'd0, vecs[i].e_m1_rv});
            check("m1_rdata", i, m1_rdata, vecs[i].e_m1_rd);
            check("starved", i, {31'd0, m0_starved}, 32'd0);
        end

        // Reset asserted the cycle after a granted m0 read.
        @(negedge clk);
        set_m0(1'b1, 4'h0, 32'h0001_0008, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        check("rst_rd_gnt", 0, {31'd0, m0_gnt}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        set_m0(1'b1, 4'hF, 32'h0001_0020, 32'h7777_7777);
        set_m1(1'b1, 4'hF, 32'h0001_0024, 32'h8888_8888);
        #2;
        check_all_zero("in_reset", 1);
        @(negedge clk);
        #2;
        check_all_zero("in_reset", 2);
        @(negedge clk);
        rst_n = 1'b1;
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            check("post_rst_rvalid", c, {31'd0, m0_rvalid}, 32'd0);
        end

`ifdef DMEM_ARB_RR_EN
        // Round-robin: first tie after reset goes to m0, then alternate.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_m0(1'b1, 4'h0, 32'h0001_0008, 32'h0);
            set_m1(1'b1, 4'h0, 32'h0001_0100, 32'h0);
            #2;
            check("rr_m0_gnt", c, {31'd0, m0_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_m1_gnt", c, {31'd0, m1_gnt}, (c % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_starved", c, {31'd0, m0_starved}, 32'd0);
        end
`else
        // Both masters held for 20 cycles: m1 forced in on cycle 16.
        n_m0 = 0; n_m1 = 0; n_st = 0; first_m1 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            set_m0(1'b1, 4'h0, 32'h0001_0008, 32'h0);
            set_m1(1'b1, 4'h0, 32'h0001_0100, 32'h0);
            #2;
            if (m0_gnt) n_m0++;
            if (m1_gnt) n_m1++;
            if (m0_starved) n_st++;
            if (m1_gnt && first_m1 == 0) first_m1 = c;
            if (c == 16) begin
                check("force_m1_gnt", c, {31'd0, m1_gnt}, 32'd1);
                check("force_m0_gnt", c, {31'd0, m0_gnt}, 32'd0);
                check("force_starved", c, {31'd0, m0_starved}, 32'd1);
            end
        end
        check("first_m1_cycle", 0, first_m1, 32'd16);
        check("m1_gnt_count", 0, n_m1, 32'd1);
        check("starved_count", 0, n_st, 32'd1);
        check("m0_gnt_count", 0, n_m0, 32'd19);

        // Idle to clear the counter, then m1 drops its request in FORCE1.
        @(negedge clk);
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            set_m0(1'b1, 4'h0, 32'h0001_0008, 32'h0);
            set_m1(c < 16, 4'h0, 32'h0001_0100, 32'h0);
            #2;
            if (c == 16) begin
                check("drop_m0_gnt", c, {31'd0, m0_gnt}, 32'd0);
                check("drop_m1_gnt", c, {31'd0, m1_gnt}, 32'd0);
                check("drop_starved", c, {31'd0, m0_starved}, 32'd0);
            end else begin
                check("drop_m0_gnt", c, {31'd0, m0_gnt}, 32'd1);
            end
        end
`endif

        @(negedge clk);
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
